// File: rtl/serial_slot_write_arbiter.sv
// serial_slot_write_arbiter: round-robin share of the serial slot-store write link.
// Ports: fifty_MHz_int_clock, reset (async high); req/slot_in/data_in per requester;
//   lock_mask per slot; grant/done/reject per requester; busy; synch/data_ctrl/serial link.
// Option: define ARB_PARITY_EN to append an odd-parity bit (16-bit frame).
module serial_slot_write_arbiter #(
    parameter int N_REQ    = 2,
    parameter int DIV      = 5,
    parameter int GAP_BITS = 2
) (
    input  logic                  fifty_MHz_int_clock,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [3*N_REQ-1:0]    slot_in,
    input  logic [12*N_REQ-1:0]   data_in,
    input  logic [7:0]            lock_mask,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      done,
    output logic [N_REQ-1:0]      reject,
    output logic                  busy,
    output logic                  ten_MHz_synch_output,
    output logic                  data_ctrl_output,
    output logic                  serial_output
);

    localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
`ifdef ARB_PARITY_EN
    localparam int FW      = 16;
`else
    localparam int FW      = 15;
`endif
    localparam int GAP_CYC = GAP_BITS * DIV;
    localparam int CW      = $clog2(GAP_CYC) + 1;
    localparam int BW      = 5;
    // synch rises after the first DIV - DIV/2 cycles so it lands mid-bit
    localparam int HI      = DIV - DIV / 2;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        SEND,
        GAP
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [IW-1:0]  ptr;
    logic [IW-1:0]  owner;
    logic [IW-1:0]  win;
    logic           win_vld;
    logic [2:0]     win_slot;
    logic [11:0]    win_data;
    logic           win_lock;
    logic [FW-1:0]  frame;

    logic [FW-1:0]  shreg;
    logic [CW-1:0]  cyc;
    logic [BW-1:0]  bitn;

    logic           period_end;
    logic           bit_last;
    logic           gap_end;

    assign period_end = (cyc == CW'(DIV - 1));
    assign bit_last   = (bitn == BW'(FW - 1));
    assign gap_end    = (cyc == CW'(GAP_CYC - 1));

    // Round-robin search starting one past the last winner.
    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        win_vld = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!win_vld && req[idx]) begin
                win     = IW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        win_slot = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IW'(i)) begin
                win_slot = slot_in[3*i +: 3];
                win_data = data_in[12*i +: 12];
            end
        end
    end

    assign win_lock = lock_mask[win_slot];

`ifdef ARB_PARITY_EN
    // odd parity: total ones over payload plus parity is odd
    assign frame = {win_slot, win_data, ~^{win_slot, win_data}};
`else
    assign frame = {win_slot, win_data};
`endif

    always_ff @(posedge fifty_MHz_int_clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt            = state;
        grant                = '0;
        done                 = '0;
        reject               = '0;
        busy                 = 1'b1;
        ten_MHz_synch_output = 1'b0;
        data_ctrl_output     = 1'b0;
        serial_output        = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (|req) begin
                    state_nxt = ARB;
                end
            end
            ARB: begin
                if (!win_vld) begin
                    state_nxt = IDLE;
                end else if (win_lock) begin
                    reject    = N_REQ'(1) << win;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                grant                = N_REQ'(1) << owner;
                data_ctrl_output     = 1'b1;
                serial_output        = shreg[FW-1];
                ten_MHz_synch_output = (cyc >= CW'(HI));
                if (period_end && bit_last) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (cyc == '0) begin
                    done = N_REQ'(1) << owner;
                end
                if (gap_end) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Reset pointer to the last index so requester 0 wins first.
    always_ff @(posedge fifty_MHz_int_clock or posedge reset) begin
        if (reset) begin
            ptr   <= IW'(N_REQ - 1);
            owner <= '0;
            shreg <= '0;
            cyc   <= '0;
            bitn  <= '0;
        end else begin
            unique case (state)
                ARB: begin
                    cyc  <= '0;
                    bitn <= '0;
                    if (win_vld) begin
                        ptr   <= win;
                        owner <= win;
                        shreg <= frame;
                    end
                end
                SEND: begin
                    if (period_end) begin
                        cyc   <= '0;
                        shreg <= shreg << 1;
                        bitn  <= bit_last ? '0 : bitn + BW'(1);
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                GAP: begin
                    cyc <= gap_end ? '0 : cyc + CW'(1);
                end
                default: begin
                    cyc  <= '0;
                    bitn <= '0;
                end
            endcase
        end
    end

endmodule
